om_frag_serializer: RTL

- Receiving end of the OM request bus. Sits at the OM unit input and accepts one multi-lane request per handshake: uuid, lane mask, and per-lane pos_x/pos_y/color/depth/face.
- Emits one single-fragment beat per active lane, in ascending lane order, to the OM per-fragment pipeline (depth/stencil, blend).
- Inactive lanes are skipped with zero bubble cycles.

---
 rtl/om_frag_serializer_pkg.sv | 36 +++
 rtl/om_frag_serializer_penc.sv | 16 +
 rtl/om_frag_serializer.sv | 127 ++++++++++++
 3 files changed

// File: rtl/om_frag_serializer_pkg.sv
// Shared widths and types for the OM request-to-fragment serializer.
// Lane index width is derived from the lane count; never override it.
package om_frag_serializer_pkg;

  localparam int UUID_WIDTH    = 44;
  localparam int DIM_BITS      = 11;
  localparam int DEPTH_BITS    = 24;
  localparam int COLOR_BITS    = 32;
  localparam int MAX_LANE_BITS = 8;
  localparam int LANE_REQ_BITS = 2*DIM_BITS + COLOR_BITS + DEPTH_BITS + 1;

  typedef struct packed {
    logic [DIM_BITS-1:0]   pos_x;
    logic [DIM_BITS-1:0]   pos_y;
    logic [COLOR_BITS-1:0] color;
    logic [DEPTH_BITS-1:0] depth;
    logic                  face;
  } lane_req_t;

  typedef struct packed {
    logic [UUID_WIDTH-1:0]    uuid;
    logic [MAX_LANE_BITS-1:0] lane;
    logic [DIM_BITS-1:0]      pos_x;
    logic [DIM_BITS-1:0]      pos_y;
    logic [COLOR_BITS-1:0]    color;
    logic [DEPTH_BITS-1:0]    depth;
    logic                     face;
    logic                     last;
  } om_frag_t;

  // A single lane still needs a one-bit index.
  function automatic int lane_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/om_frag_serializer_penc.sv
// Lowest-set-bit priority encoder; returns 0 for an all-zero input.
module VX_priority_encoder #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  data_in,
  output logic [IW-1:0] index
);

  always_comb begin
    index = '0;
    for (int i = N-1; i >= 0; i--)
      if (data_in[i]) index = IW'(i);
  end

endmodule

// File: rtl/om_frag_serializer.sv
// Splits one multi-lane OM request into one fragment beat per active lane, lowest lane first.
// Optional VX_OM_SER_PERF_EN adds request/fragment/stall counters.
module om_frag_serializer
  import om_frag_serializer_pkg::*;
#(
  parameter  int NUM_LANES = 4,
  localparam int LANE_BITS = lane_bits(NUM_LANES)
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  req_valid,
  output logic                                  req_ready,
  input  logic [UUID_WIDTH-1:0]                 req_uuid,
  input  logic [NUM_LANES-1:0]                  req_mask,
  input  logic [NUM_LANES-1:0][DIM_BITS-1:0]    req_pos_x,
  input  logic [NUM_LANES-1:0][DIM_BITS-1:0]    req_pos_y,
  input  logic [NUM_LANES-1:0][COLOR_BITS-1:0]  req_color,
  input  logic [NUM_LANES-1:0][DEPTH_BITS-1:0]  req_depth,
  input  logic [NUM_LANES-1:0]                  req_face,
  output logic                                  frag_valid,
  input  logic                                  frag_ready,
  output logic [UUID_WIDTH-1:0]                 frag_uuid,
  output logic [LANE_BITS-1:0]                  frag_lane,
  output logic [DIM_BITS-1:0]                   frag_pos_x,
  output logic [DIM_BITS-1:0]                   frag_pos_y,
  output logic [COLOR_BITS-1:0]                 frag_color,
  output logic [DEPTH_BITS-1:0]                 frag_depth,
  output logic                                  frag_face,
  output logic                                  frag_last
`ifdef VX_OM_SER_PERF_EN
  ,
  output logic [43:0]                           perf_reqs,
  output logic [43:0]                           perf_frags,
  output logic [43:0]                           perf_stalls
`endif
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                     state;
  logic [NUM_LANES-1:0]       rem_mask;
  logic [NUM_LANES-1:0]       rem_rest;
  logic [UUID_WIDTH-1:0]      uuid_q;
  lane_req_t [NUM_LANES-1:0]  lane_q;
  logic [LANE_BITS-1:0]       lane;
  lane_req_t                  cur;
  om_frag_t                   frag;
  logic                       frag_fire;
  logic                       req_fire;

  VX_priority_encoder #(.N(NUM_LANES)) u_penc (
    .data_in (rem_mask),
    .index   (lane)
  );

  // Clearing the lowest set bit both retires the current lane and tells us if it was the last.
  assign rem_rest = rem_mask & (rem_mask - NUM_LANES'(1));
  assign cur      = lane_q[lane];

  always_comb begin
    frag       = '0;
    frag.uuid  = uuid_q;
    frag.lane  = MAX_LANE_BITS'(lane);
    frag.pos_x = cur.pos_x;
    frag.pos_y = cur.pos_y;
    frag.color = cur.color;
    frag.depth = cur.depth;
    frag.face  = cur.face;
    frag.last  = (rem_mask != '0) && (rem_rest == '0);
  end

  assign frag_valid = (state == BUSY);
  assign frag_fire  = frag_valid && frag_ready;
  assign req_ready  = (state == IDLE) || (frag_fire && frag.last);
  assign req_fire   = req_valid && req_ready;

  assign frag_uuid  = frag.uuid;
  assign frag_lane  = frag.lane[LANE_BITS-1:0];
  assign frag_pos_x = frag.pos_x;
  assign frag_pos_y = frag.pos_y;
  assign frag_color = frag.color;
  assign frag_depth = frag.depth;
  assign frag_face  = frag.face;
  assign frag_last  = frag.last;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      rem_mask <= '0;
    end else if (req_fire) begin
      // An empty mask is consumed here and never leaves IDLE.
      rem_mask <= req_mask;
      state    <= (req_mask != '0) ? BUSY : IDLE;
    end else if (frag_fire) begin
      rem_mask <= rem_rest;
      if (frag.last) state <= IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) begin
      uuid_q <= req_uuid;
      for (int i = 0; i < NUM_LANES; i++) begin
        lane_q[i].pos_x <= req_pos_x[i];
        lane_q[i].pos_y <= req_pos_y[i];
        lane_q[i].color <= req_color[i];
        lane_q[i].depth <= req_depth[i];
        lane_q[i].face  <= req_face[i];
      end
    end
  end

`ifdef VX_OM_SER_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_reqs   <= '0;
      perf_frags  <= '0;
      perf_stalls <= '0;
    end else begin
      perf_reqs   <= perf_reqs   + 44'(req_fire);
      perf_frags  <= perf_frags  + 44'(frag_fire);
      perf_stalls <= perf_stalls + 44'(frag_valid && !frag_ready);
    end
  end
`endif

endmodule
